// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite memory slave: word-organised RAM with byte-lane writes, optional wait
// states and a two-cycle ERROR response for misaligned, oversized or out-of-range
// transfers. Define AHB3LITE_MEM_SLAVE_WAIT_EN to insert WAIT_STATES wait cycles per
// OKAY transfer; without it every OKAY transfer completes with zero wait states.
module ahb3lite_mem_slave #(
   parameter int unsigned DATA_SIZE   = 32,
   parameter int unsigned ADDR_SIZE   = 32,
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic                 HSEL,
   input  logic [ADDR_SIZE-1:0] HADDR,
   input  logic [DATA_SIZE-1:0] HWDATA,
   input  logic                 HWRITE,
   input  logic [2:0]           HSIZE,
   input  logic [2:0]           HBURST,
   input  logic [3:0]           HPROT,
   input  logic [1:0]           HTRANS,
   input  logic                 HMASTLOCK,
   input  logic                 HREADY,
   output logic [DATA_SIZE-1:0] HRDATA,
   output logic                 HREADYOUT,
   output logic                 HRESP
);

   localparam int unsigned BYTES = DATA_SIZE / 8;
   localparam int unsigned BW    = $clog2(BYTES);
   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [ADDR_SIZE-1:0] DEPTH_A = ADDR_SIZE'(MEM_DEPTH);

   typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

   state_e               state_q, state_d, accept_st;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [2:0]           size_q, size_d;
   logic                 write_q, write_d;
   logic [DATA_SIZE-1:0] hrdata_q, hrdata_d;
   logic [DATA_SIZE-1:0] mem [MEM_DEPTH];
   logic [IDX_W-1:0]     idx;
   logic [DATA_SIZE-1:0] rd_word;
   logic [BYTES-1:0]     byte_en;
   logic                 accept, illegal, can_accept, mem_we;

`ifdef AHB3LITE_MEM_SLAVE_WAIT_EN
   localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   logic [3:0] cnt_q, cnt_d;
`else
   logic [3:0] unused_ws;
   assign unused_ws = 4'(WAIT_STATES);
`endif

   // Burst, protection and lock attributes carry no meaning for a plain memory.
   logic unused_ok;
   assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], addr_q};

   assign accept  = HSEL && HREADY && HTRANS[1];
   assign idx     = addr_q[BW +: IDX_W];
   assign rd_word = mem[idx];
   assign mem_we  = (state_q == StData) && write_q;
   // Live memory word during a read data phase so a write just before is visible.
   assign HRDATA  = ((state_q == StData) && !write_q) ? rd_word : hrdata_q;

   // Classify the address phase on the bus and pick where an accept would lead.
   always_comb begin
      illegal = 1'b0;
      if (int'(HSIZE) > int'(BW)) illegal = 1'b1;
      if ((HADDR & ((ADDR_SIZE'(1) << HSIZE) - ADDR_SIZE'(1))) != '0) illegal = 1'b1;
      if ((HADDR >> BW) >= DEPTH_A) illegal = 1'b1;
`ifdef AHB3LITE_MEM_SLAVE_WAIT_EN
      accept_st = illegal ? StErr1 : ((WAIT_STATES > 0) ? StWait : StData);
`else
      accept_st = illegal ? StErr1 : StData;
`endif
   end

   // Byte lanes touched by the captured transfer (little-endian).
   always_comb begin
      byte_en = '0;
      for (int b = 0; b < int'(BYTES); b++) begin
         if ((b >= int'(addr_q[BW-1:0])) && (b < int'(addr_q[BW-1:0]) + (1 << size_q))) begin
            byte_en[b] = 1'b1;
         end
      end
   end

   // Next-state and response outputs.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      write_d    = write_q;
      hrdata_d   = hrdata_q;
      HREADYOUT  = 1'b1;
      HRESP      = 1'b0;
      can_accept = 1'b0;
`ifdef AHB3LITE_MEM_SLAVE_WAIT_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         StIdle: can_accept = 1'b1;
`ifdef AHB3LITE_MEM_SLAVE_WAIT_EN
         StWait: begin
            HREADYOUT = 1'b0;
            if (cnt_q == WS_LAST) begin
               cnt_d   = 4'd0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
`endif
         StData: begin
            if (!write_q) hrdata_d = rd_word;
            can_accept = 1'b1;
         end
         StErr1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = StErr2;
         end
         StErr2: begin
            HRESP      = 1'b1;
            can_accept = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      if (can_accept) begin
         state_d = StIdle;
         if (accept) begin
            state_d = accept_st;
            addr_d  = HADDR;
            size_d  = HSIZE;
            write_d = HWRITE;
         end
      end
   end

   // Control state; reset aborts any transfer in flight.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         size_q   <= 3'd0;
         write_q  <= 1'b0;
         hrdata_q <= '0;
`ifdef AHB3LITE_MEM_SLAVE_WAIT_EN
         cnt_q    <= 4'd0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         write_q  <= write_d;
         hrdata_q <= hrdata_d;
`ifdef AHB3LITE_MEM_SLAVE_WAIT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   // Memory array, not reset; written on the edge that ends a write data phase.
   always_ff @(posedge HCLK) begin
      if (mem_we) begin
         for (int b = 0; b < int'(BYTES); b++) begin
            if (byte_en[b]) mem[idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Self-checking bench for ahb3lite_mem_slave: pipelined AHB master with a memory model
// and an expected-response scoreboard, plus directed reset/idle checks.
module tb_ahb3lite_mem_slave;

   localparam int DEPTH = 256;
   localparam int WS    = 1;
`ifdef AHB3LITE_MEM_SLAVE_WAIT_EN
   localparam int EXP_WS = WS;
`else
   localparam int EXP_WS = 0;
`endif

   logic        hclk, hreset, hsel, hwrite, hmastlock;
   logic [31:0] haddr, hwdata, hrdata;
   logic [2:0]  hsize, hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hreadyout, hresp;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct packed {
      logic        write;
      logic        err;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  waits;
   } exp_t;

   xfer_t       seq[$];
   exp_t        sb[$];
   logic [31:0] model [DEPTH];
   logic [31:0] last_rdata;
   int          n_total, n_bad;

   ahb3lite_mem_slave #(
      .DATA_SIZE(32), .ADDR_SIZE(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS)
   ) dut (
      .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HWDATA(hwdata),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans),
      .HMASTLOCK(hmastlock), .HREADY(hreadyout), .HRDATA(hrdata), .HREADYOUT(hreadyout),
      .HRESP(hresp)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   task automatic push_xfer(input logic w, input logic [31:0] a, input logic [2:0] s,
                            input logic [31:0] d);
      xfer_t x;
      x.write = w; x.addr = a; x.size = s; x.wdata = d;
      seq.push_back(x);
   endtask

   // Expected response for an accepted transfer; keeps the memory model current.
   function automatic exp_t model_issue(input xfer_t x);
      exp_t       e;
      logic [7:0] wi;
      int         lane;
      e.write = x.write;
      e.wdata = x.wdata;
      e.rdata = '0;
      e.err   = (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 0) ||
                ((x.addr >> 2) >= DEPTH);
      e.waits = 4'd1;
      if (!e.err) begin
         e.waits = 4'(EXP_WS);
         wi = x.addr[9:2];
         if (x.write) begin
            for (int b = 0; b < (1 << x.size); b++) begin
               lane = int'(x.addr[1:0]) + b;
               model[wi][lane*8 +: 8] = x.wdata[lane*8 +: 8];
            end
         end else begin
            e.rdata = model[wi];
         end
      end
      return e;
   endfunction

   // Drives the queued transfers back to back; starts and ends at posedge+1.
   task automatic run_seq(input string name);
      xfer_t cur;
      exp_t  e;
      bit    have_cur = 0;
      int    waits = 0;
      int    budget = 0;
      logic  rdy;
      while ((seq.size() > 0 || have_cur || sb.size() > 0) && budget < 200) begin
         budget++;
         if (!have_cur && seq.size() > 0) begin
            cur = seq.pop_front();
            have_cur = 1;
         end
         hsel = 1'b1;
         if (have_cur) begin
            htrans = 2'b10; haddr = cur.addr; hwrite = cur.write; hsize = cur.size;
         end else begin
            htrans = 2'b00; hwrite = 1'b0;
         end
         if (sb.size() > 0 && sb[0].write) hwdata = sb[0].wdata;
         else hwdata = $urandom();
         @(negedge hclk);
         rdy = hreadyout;
         if (sb.size() > 0) begin
            e = sb[0];
            n_total++;
            if (hresp !== e.err) begin
               n_bad++;
               $display("FAIL %s hresp addr=%h: got %b want %b", name, haddr, hresp, e.err);
            end
            if (rdy !== 1'b1) begin
               waits++;
            end else begin
               void'(sb.pop_front());
               n_total++;
               if (waits != int'(e.waits)) begin
                  n_bad++;
                  $display("FAIL %s waits: got %0d want %0d", name, waits, e.waits);
               end
               if (!e.write && !e.err) begin
                  n_total++;
                  if (hrdata !== e.rdata) begin
                     n_bad++;
                     $display("FAIL %s hrdata: got %h want %h", name, hrdata, e.rdata);
                  end
                  last_rdata = e.rdata;
               end
               waits = 0;
            end
         end
         if (have_cur && rdy === 1'b1) begin
            sb.push_back(model_issue(cur));
            have_cur = 0;
         end
         @(posedge hclk);
         #1;
      end
      htrans = 2'b00;
      hwrite = 1'b0;
      n_total++;
      if (seq.size() > 0 || have_cur || sb.size() > 0) begin
         n_bad++;
         $display("FAIL %s timeout: got %0d pending want 0", name, seq.size() + sb.size());
         seq.delete();
         sb.delete();
      end
   endtask

   task automatic test_reset();
      hreset = 1'b1; hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0; hsize = 3'd2;
      hburst = 3'd0; hprot = 4'd0; htrans = 2'b00; hmastlock = 1'b0; last_rdata = '0;
      #2;
      n_total++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset outputs: got rdy=%b resp=%b rdata=%h want 1 0 0",
                  hreadyout, hresp, hrdata);
      end
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      hreset = 1'b0;
      @(posedge hclk);
      #1;
   endtask

   task automatic test_write_read();
      push_xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
      run_seq("write_10");
      push_xfer(1'b0, 32'h10, 3'd2, 32'h0);
      run_seq("read_10");
   endtask

   task automatic test_back_to_back();
      push_xfer(1'b1, 32'h20, 3'd2, 32'h11223344);
      push_xfer(1'b0, 32'h20, 3'd2, 32'h0);
      run_seq("b2b_20");
   endtask

   task automatic test_byte_write();
      push_xfer(1'b1, 32'h23, 3'd0, 32'hAA000000);
      push_xfer(1'b0, 32'h20, 3'd2, 32'h0);
      push_xfer(1'b1, 32'h20, 3'd1, 32'h0000BEEF);
      push_xfer(1'b0, 32'h20, 3'd2, 32'h0);
      push_xfer(1'b1, 32'h22, 3'd1, 32'h5A5A0000);
      push_xfer(1'b0, 32'h20, 3'd2, 32'h0);
      run_seq("byte_lanes");
   endtask

   task automatic test_error();
      push_xfer(1'b0, 32'h2, 3'd2, 32'h0);
      push_xfer(1'b0, DEPTH * 4, 3'd2, 32'h0);
      push_xfer(1'b1, 32'h12, 3'd2, 32'h0BADF00D);
      push_xfer(1'b1, 32'h10, 3'd3, 32'h0BADF00D);
      push_xfer(1'b1, 32'h11, 3'd1, 32'h0BADF00D);
      push_xfer(1'b0, 32'h10, 3'd2, 32'h0);
      push_xfer(1'b1, DEPTH * 4 - 4, 3'd2, 32'hCAFEF00D);
      push_xfer(1'b0, DEPTH * 4 - 4, 3'd2, 32'h0);
      run_seq("error");
   endtask

   task automatic test_idle_busy();
      for (int i = 0; i < 3; i++) begin
         hsel   = (i < 2);
         htrans = (i == 0) ? 2'b00 : ((i == 1) ? 2'b01 : 2'b10);
         haddr  = 32'h20; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'hFFFFFFFF;
         @(negedge hclk);
         n_total++;
         if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== last_rdata) begin
            n_bad++;
            $display("FAIL idle_busy[%0d]: got rdy=%b resp=%b rdata=%h want 1 0 %h",
                     i, hreadyout, hresp, hrdata, last_rdata);
         end
         @(posedge hclk);
         #1;
      end
      hsel = 1'b1; htrans = 2'b00; hwrite = 1'b0;
      push_xfer(1'b0, 32'h20, 3'd2, 32'h0);
      run_seq("idle_unchanged");
   endtask

   task automatic test_throughput();
      for (int i = 0; i < 4; i++) push_xfer(1'b1, 32'h80 + 4 * i, 3'd2, $urandom());
      for (int i = 0; i < 4; i++) push_xfer(1'b0, 32'h80 + 4 * i, 3'd2, 32'h0);
      run_seq("stream");
   endtask

   task automatic test_reset_abort();
      push_xfer(1'b1, 32'h40, 3'd2, 32'h5555AAAA);
      push_xfer(1'b0, 32'h40, 3'd2, 32'h0);
      run_seq("preload_40");
      hsel = 1'b1; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
      @(posedge hclk);
      #1;
      htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFF0000;
      n_total++;
      if (hreadyout !== ((EXP_WS > 0) ? 1'b0 : 1'b1)) begin
         n_bad++;
         $display("FAIL abort phase rdy: got %b want %b", hreadyout, (EXP_WS > 0));
      end
      #2;
      hreset = 1'b1;
      #1;
      n_total++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
         n_bad++;
         $display("FAIL abort reset outputs: got rdy=%b resp=%b rdata=%h want 1 0 0",
                  hreadyout, hresp, hrdata);
      end
      @(posedge hclk);
      @(negedge hclk);
      hreset = 1'b0;
      @(posedge hclk);
      #1;
      push_xfer(1'b0, 32'h40, 3'd2, 32'h0);
      run_seq("abort_kept_40");
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      test_reset();
      test_write_read();
      test_back_to_back();
      test_byte_write();
      test_error();
      test_idle_busy();
      test_throughput();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
